// File: rtl/ysyx_22040632_dmem_axi_bridge.sv
// Uncached data-side AXI4 master: one single-beat read or write per MEM request.
// Optional macro YSYX_22040632_DMEM_POSTED_WRITE_EN completes writes before B arrives.
module ysyx_22040632_dmem_axi_bridge #(
  parameter int unsigned     ID_W   = 4,
  parameter logic [ID_W-1:0] AXI_ID = ID_W'(1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_rw_i,
  input  logic [31:0]     req_addr_i,
  input  logic [2:0]      req_size_i,
  input  logic [7:0]      req_wmask_i,
  input  logic [63:0]     req_wdata_i,
  output logic [63:0]     rdata_o,
  output logic            resp_err_o,
  output logic            arvalid_o,
  input  logic            arready_i,
  output logic [31:0]     araddr_o,
  output logic [2:0]      arsize_o,
  output logic [7:0]      arlen_o,
  output logic [1:0]      arburst_o,
  output logic [ID_W-1:0] arid_o,
  input  logic            rvalid_i,
  output logic            rready_o,
  input  logic [63:0]     rdata_axi_i,
  input  logic [1:0]      rresp_i,
  input  logic            rlast_i,
  input  logic [ID_W-1:0] rid_i,
  output logic            awvalid_o,
  input  logic            awready_i,
  output logic [31:0]     awaddr_o,
  output logic [2:0]      awsize_o,
  output logic [7:0]      awlen_o,
  output logic [1:0]      awburst_o,
  output logic [ID_W-1:0] awid_o,
  output logic            wvalid_o,
  input  logic            wready_i,
  output logic [63:0]     wdata_o,
  output logic [7:0]      wstrb_o,
  output logic            wlast_o,
  input  logic            bvalid_i,
  output logic            bready_o,
  input  logic [1:0]      bresp_i,
  input  logic [ID_W-1:0] bid_i
);

  typedef enum logic [2:0] {
    IDLE, RD_A, RD_D, WR_AW, WR_B, DONE, WAIT_B
  } state_e;

  state_e      state_q;
  logic [31:0] addr_q;
  logic [2:0]  size_q;
  logic [7:0]  wmask_q;
  logic [63:0] wdata_q;
  logic        rw_q;
  logic        arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
  logic        req_ready_q, resp_err_q;
  logic [63:0] rdata_q;

  logic [63:0] rdata_d;
  logic        aw_done_d, w_done_d;

  // Single-outstanding scheme makes IDs and rlast redundant.
  logic unused_inputs;
  assign unused_inputs = ^{rlast_i, rid_i, bid_i, bresp_i, rw_q};

  assign rdata_d   = rdata_axi_i >> {addr_q[2:0], 3'b000};
  assign aw_done_d = !awvalid_q || awready_i;
  assign w_done_d  = !wvalid_q || wready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      size_q      <= '0;
      wmask_q     <= '0;
      wdata_q     <= '0;
      rw_q        <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      req_ready_q <= 1'b0;
      resp_err_q  <= 1'b0;
      rdata_q     <= '0;
    end else begin
      req_ready_q <= 1'b0;
      resp_err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            addr_q  <= req_addr_i;
            size_q  <= req_size_i;
            wmask_q <= req_wmask_i;
            wdata_q <= req_wdata_i;
            rw_q    <= req_rw_i;
            if (req_rw_i) begin
              state_q   <= WR_AW;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
            end else begin
              state_q   <= RD_A;
              arvalid_q <= 1'b1;
            end
          end
        end
        RD_A: begin
          if (arready_i) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RD_D;
          end
        end
        RD_D: begin
          if (rvalid_i) begin
            rready_q    <= 1'b0;
            rdata_q     <= rdata_d;
            resp_err_q  <= (rresp_i != 2'b00);
            req_ready_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        WR_AW: begin
          // AW and W complete independently; each valid drops after its own handshake.
          if (awvalid_q && awready_i) awvalid_q <= 1'b0;
          if (wvalid_q && wready_i) wvalid_q <= 1'b0;
          if (aw_done_d && w_done_d) begin
`ifdef YSYX_22040632_DMEM_POSTED_WRITE_EN
            state_q     <= DONE;
            req_ready_q <= 1'b1;
`else
            state_q     <= WR_B;
            bready_q    <= 1'b1;
`endif
          end
        end
        WR_B: begin
          if (bvalid_i) begin
            bready_q    <= 1'b0;
            resp_err_q  <= (bresp_i != 2'b00);
            req_ready_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
`ifdef YSYX_22040632_DMEM_POSTED_WRITE_EN
          // A posted write still owes its B beat before another request is taken.
          if (rw_q) begin
            state_q  <= WAIT_B;
            bready_q <= 1'b1;
          end else begin
            state_q  <= IDLE;
          end
`else
          state_q <= IDLE;
`endif
        end
        WAIT_B: begin
          if (bvalid_i) begin
            bready_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o = req_ready_q;
  assign resp_err_o  = resp_err_q;
  assign rdata_o     = rdata_q;

  assign arvalid_o   = arvalid_q;
  assign araddr_o    = addr_q;
  assign arsize_o    = size_q;
  assign arlen_o     = 8'd0;
  assign arburst_o   = 2'b01;
  assign arid_o      = AXI_ID;
  assign rready_o    = rready_q;

  assign awvalid_o   = awvalid_q;
  assign awaddr_o    = addr_q;
  assign awsize_o    = size_q;
  assign awlen_o     = 8'd0;
  assign awburst_o   = 2'b01;
  assign awid_o      = AXI_ID;
  assign wvalid_o    = wvalid_q;
  assign wdata_o     = wdata_q;
  assign wstrb_o     = wmask_q;
  assign wlast_o     = 1'b1;
  assign bready_o    = bready_q;

endmodule

// File: tb/tb_ysyx_22040632_dmem_axi_bridge.sv
// Scoreboard bench for the data-side AXI bridge: random requests against a
// behavioural slave and reference model; honours YSYX_22040632_DMEM_POSTED_WRITE_EN.
module tb_ysyx_22040632_dmem_axi_bridge;

`ifdef YSYX_22040632_DMEM_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  typedef struct {
    bit          rw;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [7:0]  wmask;
    logic [63:0] wdata;
    logic [63:0] sdata;
    logic [1:0]  resp;
    int          dA;
    int          dW;
    int          dR;
    int          dB;
    bit          hang;
  } txn_t;

  typedef struct {
    logic [63:0] rdata;
    bit          err;
    int          issue;
    int          lat;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        reqValid, reqRw;
  logic [31:0] reqAddr;
  logic [2:0]  reqSize;
  logic [7:0]  reqWmask;
  logic [63:0] reqWdata;
  logic        arready, rvalid, rlast, awready, wready, bvalid;
  logic [63:0] rdataAxi;
  logic [1:0]  rresp, bresp;
  logic [3:0]  rid, bid;

  logic        req_ready_o, resp_err_o;
  logic [63:0] rdata_o;
  logic        arvalid_o, rready_o, awvalid_o, wvalid_o, wlast_o, bready_o;
  logic [31:0] araddr_o, awaddr_o;
  logic [2:0]  arsize_o, awsize_o;
  logic [7:0]  arlen_o, awlen_o, wstrb_o;
  logic [1:0]  arburst_o, awburst_o;
  logic [3:0]  arid_o, awid_o;
  logic [63:0] wdata_o;

  ysyx_22040632_dmem_axi_bridge #(.ID_W(4), .AXI_ID(4'd1)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(reqValid), .req_ready_o(req_ready_o), .req_rw_i(reqRw),
    .req_addr_i(reqAddr), .req_size_i(reqSize), .req_wmask_i(reqWmask),
    .req_wdata_i(reqWdata), .rdata_o(rdata_o), .resp_err_o(resp_err_o),
    .arvalid_o(arvalid_o), .arready_i(arready), .araddr_o(araddr_o),
    .arsize_o(arsize_o), .arlen_o(arlen_o), .arburst_o(arburst_o), .arid_o(arid_o),
    .rvalid_i(rvalid), .rready_o(rready_o), .rdata_axi_i(rdataAxi),
    .rresp_i(rresp), .rlast_i(rlast), .rid_i(rid),
    .awvalid_o(awvalid_o), .awready_i(awready), .awaddr_o(awaddr_o),
    .awsize_o(awsize_o), .awlen_o(awlen_o), .awburst_o(awburst_o), .awid_o(awid_o),
    .wvalid_o(wvalid_o), .wready_i(wready), .wdata_o(wdata_o), .wstrb_o(wstrb_o),
    .wlast_o(wlast_o),
    .bvalid_i(bvalid), .bready_o(bready_o), .bresp_i(bresp), .bid_i(bid)
  );

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  logic [63:0] lastRdata = '0;
  txn_t        slvQ[$];
  exp_t        expQ[$];
  exp_t        mon;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void checkOutput(input string name, input logic [63:0] act,
                                      input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endfunction

  task automatic timeoutAbort(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: timed out waiting on the DUT", name);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  endtask

  // Reference model: predict load alignment, error flag and latency, then issue the request.
  task automatic applyStimulus(input txn_t t);
    exp_t e;
    int   n;
    int   mx;
    mx = (t.dA > t.dW) ? t.dA : t.dW;
    if (!t.rw) begin
      if (!t.hang) lastRdata = t.sdata >> (8 * t.addr[2:0]);
      e.err = (t.resp != 2'b00);
      e.lat = POSTED ? -1 : 3 + t.dA + t.dR;
    end else begin
      e.err = POSTED ? 1'b0 : (t.resp != 2'b00);
      e.lat = POSTED ? 2 + mx : 3 + mx + t.dB;
    end
    e.rdata = lastRdata;
    e.issue = cyc;
    slvQ.push_back(t);
    if (!t.hang) expQ.push_back(e);
    reqValid = 1'b1;
    reqRw    = t.rw;
    reqAddr  = t.addr;
    reqSize  = t.size;
    reqWmask = t.wmask;
    reqWdata = t.wdata;
    n = 0;
    if (t.hang) begin
      while (!rready_o) begin
        @(negedge clk);
        n++;
        if (n > 100) timeoutAbort("hang_read_rready");
      end
    end else begin
      while (!req_ready_o) begin
        @(negedge clk);
        n++;
        if (n > 300) timeoutAbort("req_ready");
      end
      @(negedge clk);
      reqValid = 1'b0;
    end
  endtask

  function automatic txn_t makeTxn(input bit rw, input logic [31:0] addr,
                                   input logic [2:0] size, input logic [7:0] wmask,
                                   input logic [63:0] wdata, input logic [63:0] sdata,
                                   input logic [1:0] resp, input int dA, input int dW,
                                   input int dR, input int dB);
    txn_t t;
    t.rw = rw; t.addr = addr; t.size = size; t.wmask = wmask; t.wdata = wdata;
    t.sdata = sdata; t.resp = resp; t.dA = dA; t.dW = dW; t.dR = dR; t.dB = dB;
    t.hang = 1'b0;
    return t;
  endfunction

  function automatic txn_t randTxn();
    txn_t t;
    t.rw    = 1'($urandom_range(0, 1));
    t.addr  = $urandom;
    t.size  = 3'($urandom_range(0, 3));
    t.wmask = 8'($urandom);
    t.wdata = {$urandom, $urandom};
    t.sdata = {$urandom, $urandom};
    t.resp  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    t.dA    = $urandom_range(0, 3);
    t.dW    = $urandom_range(0, 3);
    t.dR    = $urandom_range(0, 3);
    t.dB    = $urandom_range(0, 4);
    t.hang  = 1'b0;
    return t;
  endfunction

  // Monitor: every completion pulse must match the oldest predicted response.
  always @(negedge clk) begin
    if (!rst && req_ready_o) begin
      if (expQ.size() == 0) begin
        checkOutput("spurious_ready", 64'(req_ready_o), 64'd0);
      end else begin
        mon = expQ.pop_front();
        checkOutput("rdata", rdata_o, mon.rdata);
        checkOutput("resp_err", 64'(resp_err_o), 64'(mon.err));
        if (mon.lat >= 0) checkOutput("latency", 64'(cyc - mon.issue), 64'(mon.lat));
      end
    end else if (!rst && resp_err_o) begin
      checkOutput("err_without_ready", 64'(resp_err_o), 64'd0);
    end
  end

  // Behavioural AXI slave with per-transaction wait states.
  initial begin : slave
    txn_t t;
    int   n;
    int   k;
    bit   awDone, wDone, awr, wr;
    arready = 0; rvalid = 0; rdataAxi = '0; rresp = 0; rlast = 1; rid = 4'd1;
    awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 4'd1;
    forever begin
      while (slvQ.size() == 0) @(negedge clk);
      t = slvQ.pop_front();
      n = 0;
      while (!(arvalid_o || awvalid_o)) begin
        @(negedge clk);
        n++;
        if (n > 200) timeoutAbort("slave_valid");
      end
      if (!t.rw) begin
        checkOutput("ar_channel_sel", 64'({arvalid_o, awvalid_o, wvalid_o}), 64'(3'b100));
        checkOutput("ar_fields", 64'({araddr_o, arsize_o, arlen_o, arburst_o, arid_o}),
                    64'({t.addr, t.size, 8'd0, 2'b01, 4'd1}));
        repeat (t.dA) @(negedge clk);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        checkOutput("ar_drop", 64'(arvalid_o), 64'd0);
        if (!t.hang) begin
          repeat (t.dR) @(negedge clk);
          rvalid = 1'b1; rdataAxi = t.sdata; rresp = t.resp;
          n = 0;
          while (!rready_o) begin
            @(negedge clk);
            n++;
            if (n > 100) timeoutAbort("rready");
          end
          @(negedge clk);
          rvalid = 1'b0; rdataAxi = {$urandom, $urandom}; rresp = 2'($urandom);
        end
      end else begin
        checkOutput("aw_channel_sel", 64'({arvalid_o, awvalid_o, wvalid_o}), 64'(3'b011));
        checkOutput("aw_fields", 64'({awaddr_o, awsize_o, awlen_o, awburst_o, awid_o}),
                    64'({t.addr, t.size, 8'd0, 2'b01, 4'd1}));
        checkOutput("w_data", wdata_o, t.wdata);
        checkOutput("w_strb_last", 64'({wstrb_o, wlast_o}), 64'({t.wmask, 1'b1}));
        awDone = 0; wDone = 0; k = 0;
        while (!(awDone && wDone)) begin
          awr = !awDone && (k >= t.dA);
          wr  = !wDone && (k >= t.dW);
          awready = awr; wready = wr;
          checkOutput("aw_w_valid_track", 64'({awvalid_o, wvalid_o}), 64'({~awDone, ~wDone}));
          @(negedge clk);
          awDone = awDone | awr;
          wDone  = wDone | wr;
          k++;
          if (k > 100) timeoutAbort("aw_w_handshake");
        end
        awready = 1'b0; wready = 1'b0;
        checkOutput("aw_w_drop", 64'({awvalid_o, wvalid_o}), 64'd0);
        for (int i = 0; i < t.dB; i++) begin
          checkOutput("no_new_req_before_b", 64'({arvalid_o, awvalid_o}), 64'd0);
          @(negedge clk);
        end
        bvalid = 1'b1; bresp = t.resp;
        n = 0;
        while (!bready_o) begin
          checkOutput("no_new_req_before_b", 64'({arvalid_o, awvalid_o}), 64'd0);
          @(negedge clk);
          n++;
          if (n > 100) timeoutAbort("bready");
        end
        @(negedge clk);
        bvalid = 1'b0; bresp = 2'($urandom);
      end
    end
  end

  initial begin : watchdog
    repeat (50000) @(posedge clk);
    timeoutAbort("watchdog");
  end

  initial begin : driver
    txn_t t;
    rst = 1'b1; reqValid = 0; reqRw = 0; reqAddr = '0; reqSize = '0;
    reqWmask = '0; reqWdata = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_ctrl",
                64'({arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o, req_ready_o, resp_err_o}),
                64'd0);
    checkOutput("reset_rdata", rdata_o, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(makeTxn(0, 32'h8000_0004, 3'b010, 8'h00, 64'd0,
                          64'h1122_3344_5566_7788, 2'b00, 0, 0, 0, 0));
    applyStimulus(makeTxn(1, 32'h8000_0003, 3'b000, 8'h08, 64'h0000_0000_AB00_0000,
                          64'd0, 2'b00, 0, 0, 0, 0));
    applyStimulus(makeTxn(1, 32'h8000_0010, 3'b011, 8'hFF, 64'hDEAD_BEEF_0123_4567,
                          64'd0, 2'b00, 2, 0, 0, 1));
    applyStimulus(makeTxn(0, 32'h8000_0021, 3'b001, 8'h00, 64'd0,
                          64'hA5A5_5A5A_F00D_CAFE, 2'b10, 1, 0, 2, 0));
    applyStimulus(makeTxn(0, 32'h8000_0007, 3'b000, 8'h00, 64'd0,
                          64'h0102_0304_0506_0708, 2'b00, 0, 0, 0, 0));

    // Abort a read sitting in the data phase.
    t = makeTxn(0, 32'h8000_0040, 3'b011, 8'h00, 64'd0, 64'd0, 2'b00, 0, 0, 0, 0);
    t.hang = 1'b1;
    applyStimulus(t);
    rst = 1'b1;
    reqValid = 1'b0;
    @(negedge clk);
    checkOutput("reset_abort_ctrl",
                64'({arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o, req_ready_o, resp_err_o}),
                64'd0);
    checkOutput("reset_abort_rdata", rdata_o, 64'd0);
    rst = 1'b0;
    lastRdata = '0;
    @(negedge clk);

    applyStimulus(makeTxn(1, 32'h8000_0100, 3'b011, 8'hF0, 64'h1111_2222_0000_0000,
                          64'd0, 2'b00, 0, 0, 0, 5));
    applyStimulus(makeTxn(0, 32'h8000_0102, 3'b001, 8'h00, 64'd0,
                          64'h8877_6655_4433_2211, 2'b00, 0, 0, 0, 0));

    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      applyStimulus(randTxn());
    end

    repeat (12) @(negedge clk);
    checkOutput("scoreboard_drained", 64'(expQ.size()), 64'd0);
    checkOutput("slave_drained", 64'(slvQ.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
